icache_refill: RTL and testbench

ICACHE_REFILL -- requirements
Module: icache_refill

---
 rtl/cache_pkg.sv | 15 +
 rtl/icache_refill_if.sv | 28 ++
 rtl/icache_refill.sv | 98 +++++++++
 tb/tb_icache_refill.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache types and default geometry for the instruction cache set and its refill engine.
package cache_pkg;

  localparam int unsigned DEF_N_CACHELINE_LENGTH = 4;
  localparam int unsigned DEF_N_CACHELINES       = 8;
  localparam int unsigned DEF_BITSIZE            = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    WRITE
  } refill_state_e;

endpackage

// File: rtl/icache_refill_if.sv
// Single-outstanding word-read bus between the refill engine (master) and memory (slave).
interface icache_refill_if #(
  parameter int unsigned BITSIZE = 32
);

  logic               mem_req_o;
  logic [31:0]        mem_addr_o;
  logic               mem_gnt_i;
  logic               mem_rvalid_i;
  logic [BITSIZE-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );

endinterface

// File: rtl/icache_refill.sv
// Instruction cache line refill: fetches one aligned line word by word, then strobes a
// round-robin victim slot in the cache set.
module icache_refill
  import cache_pkg::*;
#(
  parameter int unsigned N_CACHELINE_LENGTH = DEF_N_CACHELINE_LENGTH,
  parameter int unsigned N_CACHELINES       = DEF_N_CACHELINES,
  parameter int unsigned BITSIZE            = DEF_BITSIZE
) (
  input  logic                                  clk,
  input  logic                                  rst_i,
  input  logic                                  miss_i,
  input  logic [31:0]                           addr_i,
  icache_refill_if.master                       mem,
  output logic [BITSIZE*N_CACHELINE_LENGTH-1:0] line_o,
  output logic [N_CACHELINES-1:0]               replace_o,
  output logic                                  busy_o,
  output logic                                  done_o
);

  localparam int unsigned     CW          = $clog2(N_CACHELINE_LENGTH);
  localparam int unsigned     VW          = $clog2(N_CACHELINES);
  localparam logic [CW-1:0]   LAST_WORD   = CW'(N_CACHELINE_LENGTH - 1);
  localparam logic [31:0]     OFFSET_MASK = 32'(N_CACHELINE_LENGTH - 1);

  refill_state_e                         state_q;
  refill_state_e                         state_d;
  logic [31:0]                           base_q;
  logic [CW-1:0]                         cnt_q;
  logic [VW-1:0]                         victim_q;
  logic [BITSIZE*N_CACHELINE_LENGTH-1:0] line_q;
  logic                                  last_word;

  assign last_word      = (cnt_q == LAST_WORD);
  assign busy_o         = (state_q != IDLE);
  assign line_o         = line_q;
  // Base is line-aligned, so the sum never carries out of the line.
  assign mem.mem_addr_o = base_q + 32'(cnt_q);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem.mem_req_o = 1'b0;
    replace_o     = '0;
    done_o        = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss_i) state_d = REQ;
      end
      REQ: begin
        mem.mem_req_o = 1'b1;
        if (mem.mem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (mem.mem_rvalid_i) state_d = last_word ? WRITE : REQ;
      end
      WRITE: begin
        replace_o[victim_q] = 1'b1;
        done_o              = 1'b1;
        state_d             = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      base_q   <= '0;
      cnt_q    <= '0;
      victim_q <= '0;
      line_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_i) begin
            base_q <= addr_i & ~OFFSET_MASK;
            cnt_q  <= '0;
          end
        end
        WAIT: begin
          if (mem.mem_rvalid_i) begin
            line_q[cnt_q * BITSIZE +: BITSIZE] <= mem.mem_rdata_i;
            if (!last_word) cnt_q <= cnt_q + 1'b1;
          end
        end
        WRITE: begin
          victim_q <= victim_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill: table-driven refills, hand-written reset/spurious
// sequences and randomized refills against a line/victim reference model.
module tb_icache_refill;
  import cache_pkg::*;

  localparam int unsigned NW = 4;
  localparam int unsigned NL = 8;
  localparam int unsigned BS = 32;

  typedef logic [127:0] w_t;

  typedef struct {
    logic [31:0] addr;
    int unsigned gnt_wait;
    int unsigned rv_wait;
    bit          inj_miss;
    bit          spurious;
    logic [31:0] exp_base;
    logic [7:0]  exp_repl;
  } vec_t;

  logic              clk;
  logic              rst_i;
  logic              miss_i;
  logic [31:0]       addr_i;
  logic [NW*BS-1:0]  line_o;
  logic [NL-1:0]     replace_o;
  logic              busy_o;
  logic              done_o;

  icache_refill_if #(.BITSIZE(BS)) mem_if ();

  icache_refill #(
    .N_CACHELINE_LENGTH(NW),
    .N_CACHELINES      (NL),
    .BITSIZE           (BS)
  ) dut (
    .clk      (clk),
    .rst_i    (rst_i),
    .miss_i   (miss_i),
    .addr_i   (addr_i),
    .mem      (mem_if),
    .line_o   (line_o),
    .replace_o(replace_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned done_cnt = 0;
  int unsigned exp_done = 0;
  int unsigned model_v  = 0;
  vec_t        vecs[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done_o === 1'b1) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input w_t act, input w_t exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Drives one whole refill as a cooperative memory and checks the bus and results.
  task automatic run_refill(input vec_t v);
    w_t          exp_line;
    logic [31:0] word;
    int unsigned lat;
    exp_line = '0;
    lat      = 0;
    addr_i   = v.addr;
    miss_i   = 1'b1;
    step(); lat++;
    miss_i   = 1'b0;
    for (int unsigned w = 0; w < NW; w++) begin
      chk("req", w_t'(mem_if.mem_req_o), w_t'(1));
      chk("req_addr", w_t'(mem_if.mem_addr_o), w_t'(v.exp_base + 32'(w)));
      for (int unsigned g = 0; g < v.gnt_wait; g++) begin
        if (v.spurious) begin
          mem_if.mem_rvalid_i = 1'b1;
          mem_if.mem_rdata_i  = 32'hDEADBEEF;
        end
        if (v.inj_miss) begin
          miss_i = 1'b1;
          addr_i = 32'h40;
        end
        step(); lat++;
        mem_if.mem_rvalid_i = 1'b0;
        miss_i              = 1'b0;
        chk("req_hold", w_t'(mem_if.mem_req_o), w_t'(1));
        chk("addr_hold", w_t'(mem_if.mem_addr_o), w_t'(v.exp_base + 32'(w)));
      end
      mem_if.mem_gnt_i = 1'b1;
      step(); lat++;
      mem_if.mem_gnt_i = 1'b0;
      chk("wait_noreq", w_t'(mem_if.mem_req_o), w_t'(0));
      for (int unsigned r = 0; r < v.rv_wait; r++) begin
        step(); lat++;
        chk("wait_busy", w_t'(busy_o), w_t'(1));
      end
      word = $urandom;
      exp_line[w*BS +: BS] = word;
      mem_if.mem_rvalid_i  = 1'b1;
      mem_if.mem_rdata_i   = word;
      step(); lat++;
      mem_if.mem_rvalid_i  = 1'b0;
    end
    chk("done", w_t'(done_o), w_t'(1));
    chk("replace", w_t'(replace_o), w_t'(v.exp_repl));
    // Edges from the miss-sampling edge to done; the inclusive cycle count is one more.
    if (v.gnt_wait == 0 && v.rv_wait == 0) chk("latency", w_t'(lat + 1), w_t'(2*NW + 2));
    exp_done++;
    step();
    chk("done_pulse", w_t'(done_o), w_t'(0));
    chk("replace_idle", w_t'(replace_o), w_t'(0));
    chk("busy_idle", w_t'(busy_o), w_t'(0));
    chk("line", w_t'(line_o), exp_line);
  endtask

  initial begin
    vec_t rv;
    w_t   saved_line;

    vecs[0] = '{32'h0000_0013, 0, 0, 1'b0, 1'b0, 32'h0000_0010, 8'h01};
    vecs[1] = '{32'h0000_0022, 3, 0, 1'b1, 1'b0, 32'h0000_0020, 8'h02};
    vecs[2] = '{32'h0000_1237, 2, 1, 1'b0, 1'b1, 32'h0000_1234, 8'h04};
    vecs[3] = '{32'hFFFF_FFFF, 0, 2, 1'b0, 1'b0, 32'hFFFF_FFFC, 8'h08};
    vecs[4] = '{32'h8000_0001, 1, 1, 1'b1, 1'b1, 32'h8000_0000, 8'h10};
    vecs[5] = '{32'h0000_0100, 0, 0, 1'b0, 1'b0, 32'h0000_0100, 8'h20};
    vecs[6] = '{32'h1234_567A, 0, 0, 1'b0, 1'b0, 32'h1234_5678, 8'h40};
    vecs[7] = '{32'h0000_0003, 2, 3, 1'b0, 1'b1, 32'h0000_0000, 8'h80};
    vecs[8] = '{32'hABCD_EF05, 0, 0, 1'b0, 1'b0, 32'hABCD_EF04, 8'h01};

    rst_i               = 1'b1;
    miss_i              = 1'b0;
    addr_i              = '0;
    mem_if.mem_gnt_i    = 1'b0;
    mem_if.mem_rvalid_i = 1'b0;
    mem_if.mem_rdata_i  = '0;
    step();
    step();
    rst_i = 1'b0;
    step();

    chk("rst_req", w_t'(mem_if.mem_req_o), w_t'(0));
    chk("rst_addr", w_t'(mem_if.mem_addr_o), w_t'(0));
    chk("rst_line", w_t'(line_o), w_t'(0));
    chk("rst_replace", w_t'(replace_o), w_t'(0));
    chk("rst_busy", w_t'(busy_o), w_t'(0));
    chk("rst_done", w_t'(done_o), w_t'(0));

    // Spurious response while idle must not touch the line.
    mem_if.mem_rvalid_i = 1'b1;
    mem_if.mem_rdata_i  = 32'hDEADBEEF;
    step();
    mem_if.mem_rvalid_i = 1'b0;
    chk("idle_spurious_line", w_t'(line_o), w_t'(0));
    chk("idle_spurious_busy", w_t'(busy_o), w_t'(0));

    for (int i = 0; i < 9; i++) run_refill(vecs[i]);
    model_v = 1;

    saved_line = w_t'(line_o);
    mem_if.mem_rvalid_i = 1'b1;
    mem_if.mem_rdata_i  = 32'hDEADBEEF;
    step();
    mem_if.mem_rvalid_i = 1'b0;
    chk("idle_spurious_hold", w_t'(line_o), saved_line);

    // Reset in WAIT after two words: abandon refill, no strobe, late response ignored.
    addr_i = 32'h0000_0080;
    miss_i = 1'b1;
    step();
    miss_i = 1'b0;
    for (int w = 0; w < 2; w++) begin
      mem_if.mem_gnt_i = 1'b1;
      step();
      mem_if.mem_gnt_i    = 1'b0;
      mem_if.mem_rvalid_i = 1'b1;
      mem_if.mem_rdata_i  = $urandom;
      step();
      mem_if.mem_rvalid_i = 1'b0;
    end
    mem_if.mem_gnt_i = 1'b1;
    step();
    mem_if.mem_gnt_i = 1'b0;
    chk("pre_rst_busy", w_t'(busy_o), w_t'(1));
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_busy", w_t'(busy_o), w_t'(0));
    chk("arst_req", w_t'(mem_if.mem_req_o), w_t'(0));
    chk("arst_addr", w_t'(mem_if.mem_addr_o), w_t'(0));
    chk("arst_line", w_t'(line_o), w_t'(0));
    chk("arst_replace", w_t'(replace_o), w_t'(0));
    chk("arst_done", w_t'(done_o), w_t'(0));
    step();
    rst_i               = 1'b0;
    mem_if.mem_rvalid_i = 1'b1;
    mem_if.mem_rdata_i  = 32'h0000_CAFE;
    step();
    mem_if.mem_rvalid_i = 1'b0;
    step();
    chk("late_rvalid_line", w_t'(line_o), w_t'(0));
    chk("late_rvalid_busy", w_t'(busy_o), w_t'(0));
    chk("late_rvalid_done_count", w_t'(done_cnt), w_t'(exp_done));
    model_v = 0;

    // Randomized refills; the model derives base and victim from the line geometry.
    for (int i = 0; i < 24; i++) begin
      rv.addr     = $urandom;
      rv.gnt_wait = $urandom_range(0, 3);
      rv.rv_wait  = $urandom_range(0, 3);
      rv.inj_miss = 1'($urandom_range(0, 1));
      rv.spurious = 1'($urandom_range(0, 1));
      rv.exp_base = (rv.addr / NW) * NW;
      rv.exp_repl = 8'(1 << model_v);
      run_refill(rv);
      model_v = (model_v + 1) % NL;
      if ($urandom_range(0, 3) == 0) step();
    end

    step();
    chk("done_count", w_t'(done_cnt), w_t'(exp_done));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
